vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 sync generator.
- Generates horizontal/vertical timing, pixel coordinates, frame/line strobes and blanked colour outputs for any VESA-style mode.
- Adds configurable sync polarity and a configurable client pipeline latency, so RGB from a multi-cycle renderer (e.g. the snake board/RAM lookup) stays aligned with the syncs.
- Sits between the game renderer and the VGA pins.

Parameters:
- H_ACTIVE, 800: visible pixels per line.
- H_FRONT, 40: horizontal front porch, in clocks.
- H_SYNC, 128: hsync pulse width, in clocks.
- H_BACK, 88: horizontal back porch. H_TOTAL = sum of the four = 1056.
- V_ACTIVE, 600: visible lines.
- V_FRONT, 1: vertical front porch, in lines.
- V_SYNC, 4: vsync width, in lines.
- V_BACK, 23: vertical back porch. V_TOTAL = 628.
- H_SYNC_POL, 0: active level of hsync (0 = active-low).
- V_SYNC_POL, 0: active level of vsync.
- COLOR_W, 4: bits per colour channel.
- CNT_W, 11: counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.
- CLIENT_LAT, 0: clocks from coordinate presentation to valid RGB at the inputs. Legal range 0..3.

Ports:
- clock_40mhz, in, 1: pixel clock.
- reset, in, 1: asynchronous, active-high reset.
- red, green, blue, in, COLOR_W each: pixel colour from the client.
- pixel_col, out, CNT_W: current column. Holds its last value while outside active columns.
- pixel_row, out, CNT_W: current row. Holds its last value while outside active rows.
- video_on, out, 1: the presented coordinate is visible.
- line_start, out, 1: one-clock pulse when pixel_col=0 on a visible row.
- frame_start, out, 1: one-clock pulse when coordinate (0,0) is presented.
- red_out, green_out, blue_out, out, COLOR_W each: blanked colour to the DAC.
- horiz_sync_out, vert_sync_out, out, 1: syncs aligned with the colour outputs.

Behaviour:
- Reset, applied asynchronously:
  - h_count = v_count = 0.
  - pixel_col, pixel_row, video_on, line_start, frame_start, all RGB outputs = 0.
  - horiz_sync_out = ~H_SYNC_POL and vert_sync_out = ~V_SYNC_POL (inactive levels).
  - All delay-line stages cleared to the blank/inactive value.
- h_count: increments every clock and wraps from H_TOTAL-1 to 0.
- v_count: increments only on that wrap, and wraps from V_TOTAL-1 to 0 on the same edge. This is an end-of-line increment, not a mid-line one.
- Stage 0 (registered, one clock after the counters):
  - pixel_col <= h_count when h_count < H_ACTIVE.
  - pixel_row <= v_count when v_count < V_ACTIVE. The boundary is strict; row V_ACTIVE is not visible.
  - video_on <= (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
  - hsync is active when H_ACTIVE+H_FRONT <= h_count < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync is active when V_ACTIVE+V_FRONT <= v_count < V_ACTIVE+V_FRONT+V_SYNC. vsync edges coincide with the h_count wrap.
- Alignment:
  - video_on, hsync and vsync pass through a delay line of CLIENT_LAT stages.
  - The outputs then register once more:
    - colour_out <= delayed video_on ? colour_in : 0.
    - horiz_sync_out / vert_sync_out <= the delayed sync at its polarity-adjusted level.
  - Total latency from coordinate presentation to pins is CLIENT_LAT+1 clocks, for colour and syncs alike.
- Strobes are registered together with the coordinates at stage 0. frame_start implies line_start.
- After reset deassertion, the first frame_start occurs on the first clock edge at which stage 0 registers h_count=0, v_count=0; no partial frame is emitted.
- Reset mid-frame: everything returns immediately to the reset state, and the next frame starts from (0,0).
- Widths: all comparisons are unsigned at CNT_W bits. Parameter sums are computed as localparams; no truncation is permitted.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input test_pattern (1 bit).
  - While it is high, the colour inputs are ignored. Output becomes eight vertical bars of width H_ACTIVE/8: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
  - The pattern is generated from the delayed column, so alignment with the syncs is unchanged.
  - Blanking still applies.
  - The switch is sampled per pixel; no frame synchronisation is required.
- When undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package vga_pkg holds:
  - the 800x600@60 and 640x480@60 timing constants as named localparam sets;
  - the colour-bar constants;
  - the default CNT_W.
- One sub-module, vga_delay_line: a parametrised depth/width shift register with async reset value. It is used for the video_on/sync alignment.

Test Plan:
- Reset held, then released at an arbitrary edge → sync outputs at inactive level, RGB=0. First frame_start arrives with pixel_col=0, pixel_row=0, and the next arrives exactly 1056*628 = 663168 clocks later.
- Defaults, CLIENT_LAT=0 → horiz_sync_out low for exactly 128 clocks, starting 841 clocks after line_start. vert_sync_out low for exactly 4*1056 clocks. Line period is 1056.
- Drive red = pixel_col[3:0] combinationally, CLIENT_LAT=0 → red_out equals the column one clock later. red_out=0 when pixel_col would be 800..1055 and on rows 600..627.
- CLIENT_LAT=2 with the client RGB delayed two clocks → the first non-zero red_out and the first sync edge shift by exactly 2 clocks versus CLIENT_LAT=0, and relative alignment is identical.
- H_SYNC_POL=1, V_SYNC_POL=1, 640x480 set (800/525 totals) → syncs idle low and pulse high. 96-clock hsync, 2-line vsync, frame period 420000 clocks.
- Assert reset at v_count=300 → all outputs go to reset values in the same cycle. After release, frame_start precedes any vsync pulse.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing sets, colour-bar encoding and default counter width.
// Used by vga_timing_gen and vga_delay_line; the bars are enabled with VGA_TEST_PATTERN_EN.
package vga_pkg;

    localparam int DEFAULT_CNT_W = 11;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FRONT  = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BACK   = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FRONT  = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BACK   = 23;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    localparam int NUM_BARS = 8;

    // Encoding is {red, green, blue}, each bit expanded to a full channel.
    typedef enum logic [2:0] {
        BAR_BLACK   = 3'b000,
        BAR_BLUE    = 3'b001,
        BAR_GREEN   = 3'b010,
        BAR_CYAN    = 3'b011,
        BAR_RED     = 3'b100,
        BAR_MAGENTA = 3'b101,
        BAR_YELLOW  = 3'b110,
        BAR_WHITE   = 3'b111
    } bar_rgb_t;

    function automatic bar_rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with an asynchronous reset value.
// A depth of zero is a plain wire.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int                 DEPTH     = 1,
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clock_40mhz,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clock_reset;
            assign unused_clock_reset = clock_40mhz ^ reset;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clock_40mhz or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= RESET_VAL;
                    end
                end else begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/coordinate generator with client-latency alignment of colour and syncs.
// Optional colour-bar source enabled by defining VGA_TEST_PATTERN_EN (adds input test_pattern).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = SVGA_H_ACTIVE,
    parameter int H_FRONT    = SVGA_H_FRONT,
    parameter int H_SYNC     = SVGA_H_SYNC,
    parameter int H_BACK     = SVGA_H_BACK,
    parameter int V_ACTIVE   = SVGA_V_ACTIVE,
    parameter int V_FRONT    = SVGA_V_FRONT,
    parameter int V_SYNC     = SVGA_V_SYNC,
    parameter int V_BACK     = SVGA_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int COLOR_W    = 4,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int CLIENT_LAT = 0
) (
    input  logic               clock_40mhz,
    input  logic               reset,
    input  logic [COLOR_W-1:0] red,
    input  logic [COLOR_W-1:0] green,
    input  logic [COLOR_W-1:0] blue,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_pattern,
`endif
    output logic [CNT_W-1:0]   pixel_col,
    output logic [CNT_W-1:0]   pixel_row,
    output logic               video_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [COLOR_W-1:0] red_out,
    output logic [COLOR_W-1:0] green_out,
    output logic [COLOR_W-1:0] blue_out,
    output logic               horiz_sync_out,
    output logic               vert_sync_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
    localparam int DL_W = 3 + CNT_W;
`else
    localparam int DL_W = 3;
`endif

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_visible;
    logic             v_visible;
    logic             hsync_act;
    logic             vsync_act;
    logic             video_d;
    logic             hsync_d;
    logic             vsync_d;
    logic [DL_W-1:0]  dl_in;
    logic [DL_W-1:0]  dl_out;
    logic [COLOR_W-1:0] pix_red;
    logic [COLOR_W-1:0] pix_green;
    logic [COLOR_W-1:0] pix_blue;

    assign h_visible = h_count < H_VIS;
    assign v_visible = v_count < V_VIS;

    // v_count advances at end of line so vsync edges land on the h_count wrap.
    always_ff @(posedge clock_40mhz or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
        end else begin
            h_count <= h_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_40mhz or posedge reset) begin
        if (reset) begin
            pixel_col   <= '0;
            pixel_row   <= '0;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync_act   <= 1'b0;
            vsync_act   <= 1'b0;
        end else begin
            if (h_visible) pixel_col <= h_count;
            if (v_visible) pixel_row <= v_count;
            video_on    <= h_visible && v_visible;
            line_start  <= (h_count == '0) && v_visible;
            frame_start <= (h_count == '0) && (v_count == '0);
            hsync_act   <= (h_count >= H_SYNC_START) && (h_count < H_SYNC_END);
            vsync_act   <= (v_count >= V_SYNC_START) && (v_count < V_SYNC_END);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    assign dl_in = {pixel_col, video_on, hsync_act, vsync_act};
`else
    assign dl_in = {video_on, hsync_act, vsync_act};
`endif

    vga_delay_line #(
        .DEPTH     (CLIENT_LAT),
        .WIDTH     (DL_W),
        .RESET_VAL ('0)
    ) u_align (
        .clock_40mhz (clock_40mhz),
        .reset       (reset),
        .din         (dl_in),
        .dout        (dl_out)
    );

    assign {video_d, hsync_d, vsync_d} = dl_out[2:0];

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / NUM_BARS > 0) ? H_ACTIVE / NUM_BARS : 1;

    logic [CNT_W-1:0] col_d;
    logic [CNT_W-1:0] bar_idx;
    bar_rgb_t         bar;

    assign col_d = dl_out[DL_W-1:3];

    // Columns past the last full bar are folded into the final (black) bar.
    always_comb begin
        bar_idx = col_d / CNT_W'(BAR_W);
        bar     = bar_colour((bar_idx > CNT_W'(NUM_BARS - 1)) ? 3'(NUM_BARS - 1) : bar_idx[2:0]);
        if (test_pattern) begin
            pix_red   = {COLOR_W{bar[2]}};
            pix_green = {COLOR_W{bar[1]}};
            pix_blue  = {COLOR_W{bar[0]}};
        end else begin
            pix_red   = red;
            pix_green = green;
            pix_blue  = blue;
        end
    end
`else
    assign pix_red   = red;
    assign pix_green = green;
    assign pix_blue  = blue;
`endif

    always_ff @(posedge clock_40mhz or posedge reset) begin
        if (reset) begin
            red_out        <= '0;
            green_out      <= '0;
            blue_out       <= '0;
            horiz_sync_out <= ~H_SYNC_POL;
            vert_sync_out  <= ~V_SYNC_POL;
        end else begin
            red_out        <= video_d ? pix_red   : '0;
            green_out      <= video_d ? pix_green : '0;
            blue_out       <= video_d ? pix_blue  : '0;
            horiz_sync_out <= hsync_d ? H_SYNC_POL : ~H_SYNC_POL;
            vert_sync_out  <= vsync_d ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken mode with CLIENT_LAT=2 and mixed sync polarity.
// Random client colour and random mid-frame resets are checked against a position-based frame model.
module tb_vga_timing_gen;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam bit HPOL = 1'b1;
    localparam bit VPOL = 1'b0;
    localparam int LAT = 2;
    localparam int CW = 4;
    localparam int NW = 11;
    localparam int NCYC = 1600;

    logic          clock_40mhz;
    logic          reset;
    logic [CW-1:0] red, green, blue;
    logic [NW-1:0] pixel_col, pixel_row;
    logic          video_on, line_start, frame_start;
    logic [CW-1:0] red_out, green_out, blue_out;
    logic          horiz_sync_out, vert_sync_out;
`ifdef VGA_TEST_PATTERN_EN
    logic          test_pattern;
    initial test_pattern = 1'b0;
`endif

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL),
        .COLOR_W(CW), .CNT_W(NW), .CLIENT_LAT(LAT)
    ) dut (
        .clock_40mhz    (clock_40mhz),
        .reset          (reset),
        .red            (red),
        .green          (green),
        .blue           (blue),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern   (test_pattern),
`endif
        .pixel_col      (pixel_col),
        .pixel_row      (pixel_row),
        .video_on       (video_on),
        .line_start     (line_start),
        .frame_start    (frame_start),
        .red_out        (red_out),
        .green_out      (green_out),
        .blue_out       (blue_out),
        .horiz_sync_out (horiz_sync_out),
        .vert_sync_out  (vert_sync_out)
    );

    initial clock_40mhz = 1'b0;
    always #5 clock_40mhz = ~clock_40mhz;

    typedef struct {
        int col, row;
        bit video, line_s, frame_s;
        int r, g, b;
        bit hs, vs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_k = 0;
    int   held_col = 0;
    int   held_row = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Drives the inputs for the coming edge and queues what the pins must show after it.
    task automatic applyStimulus(input bit rst_next);
        exp_t e;
        int p, h, v, q, qh, qv;
        bit vis;
        reset = rst_next;
        red   = CW'($urandom_range(0, 15));
        green = CW'($urandom_range(0, 15));
        blue  = CW'($urandom_range(0, 15));
        if (rst_next) begin
            edge_k = 0; held_col = 0; held_row = 0;
            e = '{col: 0, row: 0, video: 0, line_s: 0, frame_s: 0,
                  r: 0, g: 0, b: 0, hs: !HPOL, vs: !VPOL};
        end else begin
            edge_k++;
            p = (edge_k - 1) % FRAME;
            h = p % HT;
            v = p / HT;
            if (h < HA) held_col = h;
            if (v < VA) held_row = v;
            e.col = held_col;
            e.row = held_row;
            e.video = (h < HA) && (v < VA);
            e.line_s = (h == 0) && (v < VA);
            e.frame_s = (p == 0);
            if (edge_k > LAT + 1) begin
                q  = (edge_k - LAT - 2) % FRAME;
                qh = q % HT;
                qv = q / HT;
                vis = (qh < HA) && (qv < VA);
                e.r = vis ? int'(red)   : 0;
                e.g = vis ? int'(green) : 0;
                e.b = vis ? int'(blue)  : 0;
                e.hs = (qh >= HA + HF && qh < HA + HF + HS) ? HPOL : !HPOL;
                e.vs = (qv >= VA + VF && qv < VA + VF + VS) ? VPOL : !VPOL;
            end else begin
                e.r = 0; e.g = 0; e.b = 0;
                e.hs = !HPOL; e.vs = !VPOL;
            end
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock_40mhz);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pixel_col",   int'(pixel_col),      e.col);
                checkOutput("pixel_row",   int'(pixel_row),      e.row);
                checkOutput("video_on",    int'(video_on),       int'(e.video));
                checkOutput("line_start",  int'(line_start),     int'(e.line_s));
                checkOutput("frame_start", int'(frame_start),    int'(e.frame_s));
                checkOutput("red_out",     int'(red_out),        e.r);
                checkOutput("green_out",   int'(green_out),      e.g);
                checkOutput("blue_out",    int'(blue_out),       e.b);
                checkOutput("hsync",       int'(horiz_sync_out), int'(e.hs));
                checkOutput("vsync",       int'(vert_sync_out),  int'(e.vs));
            end
        end
    end

    initial begin : stimulus
        int r1, d1, r2, d2;
        bit rst_next, was_reset;
        r1 = 300 + $urandom_range(0, 200);
        d1 = $urandom_range(1, 3);
        r2 = 1000 + $urandom_range(0, 200);
        d2 = $urandom_range(1, 3);
        applyStimulus(1'b1);
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clock_40mhz);
            rst_next = (c < 3) || (c >= r1 && c < r1 + d1) || (c >= r2 && c < r2 + d2);
            was_reset = reset;
            applyStimulus(rst_next);
            if (rst_next && !was_reset) begin
                #1;
                checkOutput("async_rst_col",   int'(pixel_col),      0);
                checkOutput("async_rst_video", int'(video_on),       0);
                checkOutput("async_rst_red",   int'(red_out),        0);
                checkOutput("async_rst_hsync", int'(horiz_sync_out), int'(!HPOL));
                checkOutput("async_rst_vsync", int'(vert_sync_out),  int'(!VPOL));
            end
        end
        @(posedge clock_40mhz);
        #2;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
